// File: rtl/pipe_pkg.sv
// Shared fetch/decode definitions: pcsource encoding, fetch FSM states and
// the default NOP word driven when IF/ID is empty.
package pipe_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT    = 2'b00,
        S_REQ     = 2'b01,
        S_HOLD    = 2'b10,
        S_DISCARD = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/pc_sel.sv
// Redirect target mux; selects the next fetch address for a non-sequential
// pcsource using the same encoding as decode.
module pc_sel
    import pipe_pkg::*;
(
    input  logic [1:0]  pcsource_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] reg_target_i,
    input  logic [31:0] jump_target_i,
    output logic [31:0] redir_addr_o
);

    always_comb begin
        redir_addr_o = branch_target_i;
        case (pcsource_i)
            PCSRC_JR: redir_addr_o = reg_target_i;
            PCSRC_J:  redir_addr_o = jump_target_i;
            default:  redir_addr_o = branch_target_i;
        endcase
    end

endmodule

// File: rtl/pipe_if.sv
// MIPS instruction-fetch stage: PC, req/ack imem handshake, one-entry skid
// buffer and IF/ID register. Define IF_PERF_CNT_EN to add fetch/flush counters.
module pipe_if
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pcsource,
    input  logic [31:0] branch_target,
    input  logic [31:0] reg_target,
    input  logic [31:0] jump_target,
    input  logic        id_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        if_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_addr_q, fetch_addr_d;
    logic [31:0]  pend_addr_q, pend_addr_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         valid_q, valid_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic [31:0]  buf_pc4_q, buf_pc4_d;

    logic [31:0]  redir_addr;
    logic [31:0]  addr_inc;
    logic         redir;
    logic         accept;

    pc_sel u_pc_sel (
        .pcsource_i      (pcsource),
        .branch_target_i (branch_target),
        .reg_target_i    (reg_target),
        .jump_target_i   (jump_target),
        .redir_addr_o    (redir_addr)
    );

    assign addr_inc = fetch_addr_q + 32'd4;
    assign redir    = valid_q & (pcsource != PCSRC_SEQ) & ~id_stall;
    assign accept   = ~valid_q | ~id_stall;

    assign imem_req  = (state_q == S_REQ) || (state_q == S_DISCARD);
    assign imem_addr = fetch_addr_q;
    assign instr     = instr_q;
    assign pc4       = pc4_q;
    assign if_valid  = valid_q;

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        pend_addr_d  = pend_addr_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        buf_instr_d  = buf_instr_q;
        buf_pc4_d    = buf_pc4_q;
        case (state_q)
            S_BOOT: state_d = S_REQ;
            S_REQ: begin
                if (redir) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    // An unacked request must complete at its old address first.
                    if (imem_ack) begin
                        fetch_addr_d = redir_addr;
                    end else begin
                        pend_addr_d = redir_addr;
                        state_d     = S_DISCARD;
                    end
                end else if (imem_ack) begin
                    fetch_addr_d = addr_inc;
                    if (accept) begin
                        instr_d = imem_rdata;
                        pc4_d   = addr_inc;
                        valid_d = 1'b1;
                    end else begin
                        buf_instr_d = imem_rdata;
                        buf_pc4_d   = addr_inc;
                        state_d     = S_HOLD;
                    end
                end else if (accept) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    valid_d      = 1'b0;
                    instr_d      = NOP_INSTR;
                    fetch_addr_d = redir_addr;
                    state_d      = S_REQ;
                end else if (!id_stall) begin
                    instr_d = buf_instr_q;
                    pc4_d   = buf_pc4_q;
                    valid_d = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DISCARD: begin
                if (imem_ack) begin
                    fetch_addr_d = pend_addr_q;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_BOOT;
            fetch_addr_q <= RESET_PC;
            pend_addr_q  <= '0;
            instr_q      <= NOP_INSTR;
            pc4_q        <= '0;
            valid_q      <= 1'b0;
            buf_instr_q  <= '0;
            buf_pc4_q    <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            pend_addr_q  <= pend_addr_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc4_q    <= buf_pc4_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((state_q == S_REQ) && imem_ack && accept && !redir) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (redir) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_if.sv
// Directed bench for pipe_if: a scoreboard of IF/ID words consumed by decode
// plus point checks of the fetch handshake, redirects, stalls and reset.
module tb_pipe_if;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] BR_T   = 32'h0040_0100;
    localparam logic [31:0] J_T    = 32'h0040_0200;
    localparam logic [31:0] WRAP_T = 32'hFFFF_FFFC;

    logic        clk;
    logic        rst;
    logic [1:0]  pcsource;
    logic [31:0] branch_target;
    logic [31:0] reg_target;
    logic [31:0] jump_target;
    logic        id_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        if_valid;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } word_t;

    word_t       exp_q[$];
    word_t       mon_e;
    int          tests = 0;
    int          fails = 0;
    int unsigned ack_lat = 0;
    int unsigned ack_cnt = 0;

    pipe_if #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pcsource      (pcsource),
        .branch_target (branch_target),
        .reg_target    (reg_target),
        .jump_target   (jump_target),
        .id_stall      (id_stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .pc4           (pc4),
        .if_valid      (if_valid)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Memory: word at address a is ~a; ack after ack_lat extra cycles of req.
    assign imem_rdata = ~imem_addr;

    initial begin
        imem_ack = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!imem_req) begin
                imem_ack = 1'b0;
                ack_cnt  = 0;
            end else if (ack_cnt >= ack_lat) begin
                imem_ack = 1'b1;
                ack_cnt  = 0;
            end else begin
                imem_ack = 1'b0;
                ack_cnt  = ack_cnt + 1;
            end
        end
    end

    // Monitor: decode consumes the IF/ID word whenever valid and not stalled.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst && if_valid && !id_stall) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL ifid_word: got instr=%h pc4=%h, required no word", instr, pc4);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (instr !== mon_e.instr || pc4 !== mon_e.pc4) begin
                        fails++;
                        $display("FAIL ifid_word: got instr=%h pc4=%h, required instr=%h pc4=%h",
                                 instr, pc4, mon_e.instr, mon_e.pc4);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL timeout: got no finish, required finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    task automatic push_word(input logic [31:0] addr);
        word_t w;
        w.instr = ~addr;
        w.pc4   = addr + 32'd4;
        exp_q.push_back(w);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #3;
    endtask

    initial begin
        rst = 1'b0; id_stall = 1'b0; pcsource = 2'b00;
        branch_target = '0; reg_target = '0; jump_target = '0;
        cyc(); cyc();

        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", if_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc4", pc4, 32'h0);
        chk("rst_addr", imem_addr, RST_PC);
        rst = 1'b1;
        #1;
        chk1("boot_req", imem_req, 1'b0);
        chk1("boot_valid", if_valid, 1'b0);

        // Back-to-back fetch, then a 3-cycle ack delay on the fourth word.
        push_word(RST_PC);
        push_word(RST_PC + 32'd4);
        push_word(RST_PC + 32'd8);
        push_word(RST_PC + 32'd12);
        cyc();
        chk1("seq_req0", imem_req, 1'b1);
        chk("seq_addr0", imem_addr, RST_PC);
        chk1("seq_valid0", if_valid, 1'b0);
        cyc();
        chk("seq_addr1", imem_addr, RST_PC + 32'd4);
        chk1("seq_valid1", if_valid, 1'b1);
        chk("seq_instr1", instr, ~RST_PC);
        chk("seq_pc4_1", pc4, 32'h0040_0004);
        cyc();
        chk("seq_addr2", imem_addr, RST_PC + 32'd8);
        ack_lat = 3;
        cyc();
        chk("dly_addr_a", imem_addr, RST_PC + 32'd12);
        chk1("dly_req_a", imem_req, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk1("dly_req", imem_req, 1'b1);
            chk("dly_addr", imem_addr, RST_PC + 32'd12);
            chk1("dly_valid", if_valid, 1'b0);
            chk("dly_instr", instr, 32'h0);
        end
        ack_lat = 0;
        cyc();
        chk1("dly_load_valid", if_valid, 1'b1);
        chk("dly_load_instr", instr, ~(RST_PC + 32'd12));

        // Decode stalls for two cycles while the next word is acked.
        push_word(RST_PC + 32'd16);
        push_word(RST_PC + 32'd20);
        id_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk1("hold_req", imem_req, 1'b0);
            chk("hold_instr", instr, ~(RST_PC + 32'd12));
            chk1("hold_valid", if_valid, 1'b1);
        end
        id_stall = 1'b0;
        cyc();
        chk("skid_instr", instr, ~(RST_PC + 32'd16));
        chk("skid_pc4", pc4, RST_PC + 32'd20);
        chk1("skid_req", imem_req, 1'b1);
        chk("skid_addr", imem_addr, RST_PC + 32'd20);
        cyc();
        chk("resume_addr", imem_addr, RST_PC + 32'd24);
        chk("resume_instr", instr, ~(RST_PC + 32'd20));

        // Taken branch with same-cycle ack squashes the younger word.
        pcsource = 2'b01;
        branch_target = BR_T;
        push_word(BR_T);
        cyc();
        chk("br_instr", instr, 32'h0);
        chk1("br_valid", if_valid, 1'b0);
        chk("br_addr", imem_addr, BR_T);
        pcsource = 2'b00;
        ack_lat = 2;
        cyc();
        chk("br_tgt_instr", instr, ~BR_T);
        chk("br_next_addr", imem_addr, BR_T + 32'd4);

        // Jump while the outstanding request is still unacked.
        pcsource = 2'b11;
        jump_target = J_T;
        push_word(J_T);
        cyc();
        chk1("j_disc_req", imem_req, 1'b1);
        chk("j_disc_addr", imem_addr, BR_T + 32'd4);
        chk1("j_disc_valid", if_valid, 1'b0);
        pcsource = 2'b00;
        cyc();
        chk("j_disc_addr2", imem_addr, BR_T + 32'd4);
        chk1("j_disc_valid2", if_valid, 1'b0);
        ack_lat = 0;
        cyc();
        chk("j_addr", imem_addr, J_T);
        chk1("j_valid0", if_valid, 1'b0);
        cyc();
        chk("j_instr", instr, ~J_T);
        chk("j_pc4", pc4, J_T + 32'd4);

        // Asynchronous reset while a word sits in the skid buffer.
        cyc();
        id_stall = 1'b1;
        cyc();
        chk1("rst_hold_req", imem_req, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk1("arst_req", imem_req, 1'b0);
        chk1("arst_valid", if_valid, 1'b0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_addr", imem_addr, RST_PC);
        cyc();
        id_stall = 1'b0;
        cyc();
        rst = 1'b1;
        push_word(RST_PC);
        cyc();
        chk1("rerun_req", imem_req, 1'b1);
        chk("rerun_addr", imem_addr, RST_PC);
        cyc();
        chk("rerun_instr", instr, ~RST_PC);
        chk("rerun_pc4", pc4, RST_PC + 32'd4);

        // Jump to the top word: pc4 and the next fetch wrap to zero.
        pcsource = 2'b11;
        jump_target = WRAP_T;
        push_word(WRAP_T);
        cyc();
        chk("wrap_addr", imem_addr, WRAP_T);
        chk1("wrap_valid0", if_valid, 1'b0);
        pcsource = 2'b00;
        cyc();
        chk("wrap_instr", instr, 32'h0000_0003);
        chk("wrap_pc4", pc4, 32'h0000_0000);
        chk("wrap_next_addr", imem_addr, 32'h0000_0000);
        cyc();
        id_stall = 1'b1;
        chk("wrap_zero_instr", instr, 32'hFFFF_FFFF);
        chk("wrap_zero_pc4", pc4, 32'h0000_0004);
        cyc();
        cyc();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_if.md
Name: pipe_if

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of the decode stage.
- Owns the PC and drives a req/ack instruction-memory handshake.
- Holds the IF/ID pipeline register (instr, pc4, valid) that decode consumes.
- Applies the pcsource redirect that decode produces from its control unit. No branch delay slot: a taken redirect squashes the younger fetch.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0000, value driven on instr when the IF/ID register is empty or flushed

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
pcsource  in  2  from decode: 00 seq, 01 branch, 10 jr, 11 j
branch_target  in  32  branch address from decode
reg_target  in  32  jr address (decode rd1)
jump_target  in  32  j address
id_stall  in  1  decode cannot accept a new instruction this cycle
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (fetch_addr register)
imem_ack  in  1  read data valid this cycle
imem_rdata  in  32  instruction word
instr  out  32  IF/ID instruction
pc4  out  32  IF/ID address of instr plus 4
if_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset: while rst=0, asynchronously force state=S_BOOT, fetch_addr=RESET_PC, instr=NOP_INSTR, pc4=0, if_valid=0, buffer cleared, imem_req=0. Applies in every state, including an outstanding request.
- Redirect condition: redir = if_valid & (pcsource!=00) & ~id_stall.
  - Target by pcsource: 01 branch_target, 10 reg_target, 11 jump_target.
  - A stalled redirect waits until stall drops.
- Accept condition: accept = ~if_valid | ~id_stall.
- Handshake rule: once imem_req=1, imem_addr stays stable until imem_ack. Memory ack latency is at least 0 extra cycles (ack may arrive in the same cycle as req).
- S_BOOT: imem_req=0. Moves to S_REQ next cycle.
- S_REQ: imem_req=1, imem_addr=fetch_addr.
  - redir with ack: drop rdata, flush IF/ID (valid=0, instr=NOP), fetch_addr<=target, stay.
  - redir without ack: flush IF/ID, latch target into pend_addr, go to S_DISCARD.
  - ack and accept: instr<=rdata, pc4<=fetch_addr+4, if_valid<=1, fetch_addr<=fetch_addr+4. Sustains one instruction per cycle.
  - ack without accept: store rdata and fetch_addr+4 in a one-entry skid buffer, fetch_addr<=fetch_addr+4, go to S_HOLD.
  - no ack, accept: if_valid<=0 (bubble), instr<=NOP.
  - no ack, no accept: IF/ID holds.
- S_HOLD: imem_req=0.
  - While id_stall=1: everything holds.
  - redir: drop buffer, flush IF/ID, fetch_addr<=target, go to S_REQ.
  - otherwise, once id_stall=0: load buffer into IF/ID (valid=1), go to S_REQ.
- S_DISCARD: imem_req=1 at the old address. On ack, drop rdata, fetch_addr<=pend_addr, go to S_REQ. No redirect can occur here because IF/ID is empty.
- Arithmetic: all +4 increments are 32-bit modulo. 0xFFFF_FFFC wraps to 0x0000_0000.
- No output ever carries X after reset.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined: adds outputs fetch_cnt[31:0] and flush_cnt[31:0], both reset to 0, both wrapping.
  - fetch_cnt increments on every accepted ack, whether or not it is later flushed.
  - flush_cnt increments on every cycle where redir=1.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - PCSRC_SEQ/BR/JR/J = 2'b00/01/10/11
  - fetch state encoding S_BOOT/S_REQ/S_HOLD/S_DISCARD
  - NOP_INSTR default
- One sub-module, pc_sel: combinational target mux (pcsource, three targets) producing redir_addr. Decode reuses the same pcsource encoding.

Test Plan:
1. RESET_PC=0x00400000, imem_ack tied 1, no stall: imem_addr 0x00400000, 0x00400004, 0x00400008 on consecutive cycles. instr/if_valid valid one cycle after each ack, with pc4=0x00400004 for the first word. if_valid=0 during reset and S_BOOT.
2. Ack delayed 3 cycles: imem_req and imem_addr stay stable for 4 cycles. if_valid=0 (instr=0) for those cycles, then exactly one word is loaded.
3. id_stall=1 for 2 cycles when ack arrives: S_HOLD entered, imem_req=0, instr unchanged. After stall drops the buffered word appears once and fetch resumes at +4. No word is lost or duplicated.
4. if_valid=1, pcsource=01, branch_target=0x00400100, ack same cycle: next cycle instr=0 and if_valid=0, and imem_addr=0x00400100.
5. pcsource=11, jump_target=0x00400200, ack withheld 2 cycles: imem_addr holds the old address until ack, that rdata is dropped, then imem_addr=0x00400200.
6. rst driven low mid-S_HOLD, asynchronous to clk: imem_req=0, if_valid=0, instr=0 immediately. After release, the first fetch is at RESET_PC.
